// File: rtl/instr_decode_stage_pkg.sv
// Shared symbols for the instruction decode stage: opcode codes, register and
// ALU symbols, byte encoding patterns and the decode FSM state type.
package instr_decode_stage_pkg;

    localparam logic [7:0] OP_NOP  = 8'd0;
    localparam logic [7:0] OP_MOV  = 8'd1;
    localparam logic [7:0] OP_LDI  = 8'd2;
    localparam logic [7:0] OP_LDX  = 8'd3;
    localparam logic [7:0] OP_STX  = 8'd4;
    localparam logic [7:0] OP_PUSH = 8'd5;
    localparam logic [7:0] OP_POP  = 8'd6;
    localparam logic [7:0] OP_JMP  = 8'd7;
    localparam logic [7:0] OP_ALU  = 8'd8;
    localparam logic [7:0] OP_CALL = 8'd9;
    localparam logic [7:0] OP_RET  = 8'd10;
    localparam logic [7:0] OP_CMP  = 8'd11;
    localparam logic [7:0] OP_HLT  = 8'd12;

    localparam logic [2:0] REG_A   = 3'd0;
    localparam logic [2:0] REG_H   = 3'd7;
    localparam logic [2:0] ALU_SUB = 3'd1;

    // Wildcard bits are '?' so these can be used directly as casez items.
    localparam logic [7:0] ENC_MOV  = 8'b00??????;
    localparam logic [7:0] ENC_LDI  = 8'b01000???;
    localparam logic [7:0] ENC_LDX  = 8'b01001???;
    localparam logic [7:0] ENC_STX  = 8'b01010???;
    localparam logic [7:0] ENC_PUSH = 8'b01011???;
    localparam logic [7:0] ENC_POP  = 8'b01100???;
    localparam logic [7:0] ENC_JMP  = 8'b01101???;
    localparam logic [7:0] ENC_ALU  = 8'b10000???;
    localparam logic [7:0] ENC_NOP  = 8'b11000000;
    localparam logic [7:0] ENC_CALL = 8'b11000001;
    localparam logic [7:0] ENC_RET  = 8'b11000010;
    localparam logic [7:0] ENC_CMP  = 8'b11000011;
    localparam logic [7:0] ENC_HLT  = 8'b11111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IMM  = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    function automatic int imm_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational decode of one instruction byte into bundle fields.
// DECODE_ILLEGAL_TRAP_EN adds the illegal flag output for undefined encodings.
module instr_field_decode
    import instr_decode_stage_pkg::*;
#(
    parameter int ALU_MODE_W = 4
) (
    input  logic [7:0]            in_byte,
    output logic [7:0]            opcode,
    output logic [2:0]            iaddr,
    output logic [2:0]            oaddr,
    output logic [2:0]            operand1,
    output logic [2:0]            operand2,
    output logic [ALU_MODE_W-1:0] alu_mode,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                  illegal,
`endif
    output logic                  has_imm
);

    logic undef;

    always_comb begin
        opcode   = OP_NOP;
        iaddr    = '0;
        oaddr    = '0;
        operand1 = in_byte[5:3];
        operand2 = in_byte[2:0];
        alu_mode = '0;
        has_imm  = 1'b0;
        undef    = 1'b0;
        casez (in_byte)
            ENC_MOV:  begin opcode = OP_MOV;  iaddr = in_byte[5:3]; oaddr = in_byte[2:0]; end
            ENC_LDI:  begin opcode = OP_LDI;  iaddr = in_byte[2:0]; has_imm = 1'b1; end
            ENC_LDX:  begin opcode = OP_LDX;  iaddr = in_byte[2:0]; end
            ENC_STX:  begin opcode = OP_STX;  oaddr = in_byte[2:0]; end
            ENC_PUSH: begin opcode = OP_PUSH; oaddr = in_byte[2:0]; end
            ENC_POP:  begin opcode = OP_POP;  iaddr = in_byte[2:0]; end
            ENC_JMP:  begin opcode = OP_JMP;  has_imm = 1'b1; end
            ENC_ALU:  begin
                opcode   = OP_ALU;
                iaddr    = REG_A;
                alu_mode = ALU_MODE_W'(in_byte[2:0]);
            end
            ENC_NOP:  opcode = OP_NOP;
            ENC_CALL: begin opcode = OP_CALL; iaddr = REG_H; oaddr = REG_H; has_imm = 1'b1; end
            ENC_RET:  opcode = OP_RET;
            ENC_CMP:  begin opcode = OP_CMP;  alu_mode = ALU_MODE_W'(ALU_SUB); end
            ENC_HLT:  opcode = OP_HLT;
            default:  undef = 1'b1;
        endcase
        // Undefined bytes become an empty NOP bundle, register fields included.
        if (undef) begin
            operand1 = '0;
            operand2 = '0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal = undef;
`endif

endmodule

// File: rtl/instr_decode_stage.sv
// Byte-stream instruction decoder: collects opcode plus little-endian immediate
// and presents one registered bundle per instruction. Option: DECODE_ILLEGAL_TRAP_EN.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ALU_MODE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            opcode,
    output logic [2:0]            iaddr,
    output logic [2:0]            oaddr,
    output logic [2:0]            operand1,
    output logic [2:0]            operand2,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic [DATA_W-1:0]     imm,
    output logic                  halted,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                  illegal,
`endif
    output logic [1:0]            dbg_state
);

    // Handshake: a byte moves when in_valid && in_ready at a rising clk edge; a
    // bundle moves when out_valid && out_ready; fields hold until the bundle moves.

    localparam int NB    = imm_bytes(DATA_W);
    localparam int CNT_W = 2;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  halted_q, halted_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [2:0]            iaddr_q, iaddr_d;
    logic [2:0]            oaddr_q, oaddr_d;
    logic [2:0]            op1_q, op1_d;
    logic [2:0]            op2_q, op2_d;
    logic [ALU_MODE_W-1:0] alu_mode_q, alu_mode_d;
    logic [DATA_W-1:0]     imm_q, imm_d;

    logic [7:0]            dec_opcode;
    logic [2:0]            dec_iaddr, dec_oaddr, dec_op1, dec_op2;
    logic [ALU_MODE_W-1:0] dec_alu_mode;
    logic                  dec_has_imm;
    logic                  in_ready_c;
    logic                  accept;
    logic                  load_op;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  dec_illegal;
    logic                  illegal_q, illegal_d;
`endif

    instr_field_decode #(
        .ALU_MODE_W (ALU_MODE_W)
    ) u_field_decode (
        .in_byte  (in_byte),
        .opcode   (dec_opcode),
        .iaddr    (dec_iaddr),
        .oaddr    (dec_oaddr),
        .operand1 (dec_op1),
        .operand2 (dec_op2),
        .alu_mode (dec_alu_mode),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal  (dec_illegal),
`endif
        .has_imm  (dec_has_imm)
    );

    // An HLT bundle leaving OUT must not pull in a byte that HALT would then drop.
    always_comb begin
        in_ready_c = 1'b0;
        if (!flush) begin
            case (state_q)
                S_IDLE, S_IMM: in_ready_c = 1'b1;
                S_OUT:         in_ready_c = out_ready && (opcode_q != OP_HLT);
                default:       in_ready_c = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        opcode_d    = opcode_q;
        iaddr_d     = iaddr_q;
        oaddr_d     = oaddr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_mode_d  = alu_mode_q;
        imm_d       = imm_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        load_op     = 1'b0;

        case (state_q)
            S_IDLE: load_op = accept;
            S_IMM: begin
                if (accept) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == CNT_W'(i)) imm_d[i*8 +: 8] = in_byte;
                    end
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        cnt_d       = '0;
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (opcode_q == OP_HLT) begin
                        state_d     = S_HALT;
                        out_valid_d = 1'b0;
                        halted_d    = 1'b1;
                    end else if (accept) begin
                        load_op = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (load_op) begin
            opcode_d   = dec_opcode;
            iaddr_d    = dec_iaddr;
            oaddr_d    = dec_oaddr;
            op1_d      = dec_op1;
            op2_d      = dec_op2;
            alu_mode_d = dec_alu_mode;
            imm_d      = '0;
            cnt_d      = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d  = dec_illegal;
`endif
            if (dec_has_imm) begin
                state_d     = S_IMM;
                out_valid_d = 1'b0;
            end else begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
            end
        end

        // Flush wins over every handshake, including leaving HALT.
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            imm_d       = '0;
            out_valid_d = 1'b0;
            halted_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            opcode_q    <= '0;
            iaddr_q     <= '0;
            oaddr_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_mode_q  <= '0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            opcode_q    <= opcode_d;
            iaddr_q     <= iaddr_d;
            oaddr_q     <= oaddr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_mode_q  <= alu_mode_d;
            imm_q       <= imm_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign opcode    = opcode_q;
    assign iaddr     = iaddr_q;
    assign oaddr     = oaddr_q;
    assign operand1  = op1_q;
    assign operand2  = op2_q;
    assign alu_mode  = alu_mode_q;
    assign imm       = imm_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed plus randomized bench for instr_decode_stage (DATA_W=16) with a
// queue-based bundle scoreboard; honours DECODE_ILLEGAL_TRAP_EN.
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = 8 + 12 + AW + DW + 1;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready, halted;
  logic [7:0]    in_byte, opcode;
  logic [2:0]    iaddr, oaddr, operand1, operand2;
  logic [AW-1:0] alu_mode;
  logic [DW-1:0] imm;
  logic [1:0]    dbg_state;
  logic          ill_obs;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic          illegal;
  assign ill_obs = illegal;
`else
  assign ill_obs = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [BW-1:0] exp_q[$];
  bit tog_en = 1'b0;

  instr_decode_stage #(.DATA_W(DW), .ALU_MODE_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .iaddr(iaddr), .oaddr(oaddr),
    .operand1(operand1), .operand2(operand2),
    .alu_mode(alu_mode), .imm(imm), .halted(halted),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model of one bundle
  function automatic logic has_imm_m(input logic [7:0] b);
    return (b[7:3] == 5'b01000) || (b[7:3] == 5'b01101) || (b == 8'hC1);
  endfunction

  function automatic logic [BW-1:0] model(input logic [7:0] b, input logic [DW-1:0] im);
    logic [7:0] op; logic [2:0] ia, oa, o1, o2; logic [AW-1:0] am; logic [DW-1:0] iv; logic il;
    op = OP_NOP; ia = 3'd0; oa = 3'd0; o1 = b[5:3]; o2 = b[2:0]; am = '0; iv = '0; il = 1'b0;
    if (b[7:6] == 2'b00) begin op = OP_MOV; ia = b[5:3]; oa = b[2:0]; end
    else if (b[7:3] == 5'b01000) begin op = OP_LDI; ia = b[2:0]; iv = im; end
    else if (b[7:3] == 5'b01001) begin op = OP_LDX; ia = b[2:0]; end
    else if (b[7:3] == 5'b01010) begin op = OP_STX; oa = b[2:0]; end
    else if (b[7:3] == 5'b01011) begin op = OP_PUSH; oa = b[2:0]; end
    else if (b[7:3] == 5'b01100) begin op = OP_POP; ia = b[2:0]; end
    else if (b[7:3] == 5'b01101) begin op = OP_JMP; iv = im; end
    else if (b[7:3] == 5'b10000) begin op = OP_ALU; ia = 3'd0; am = AW'(b[2:0]); end
    else if (b == 8'hC0) op = OP_NOP;
    else if (b == 8'hC1) begin op = OP_CALL; ia = 3'd7; oa = 3'd7; iv = im; end
    else if (b == 8'hC2) op = OP_RET;
    else if (b == 8'hC3) begin op = OP_CMP; am = AW'(3'd1); end
    else if (b == 8'hFF) op = OP_HLT;
    else begin o1 = 3'd0; o2 = 3'd0; il = TRAP; end
    return {op, ia, oa, o1, o2, am, iv, il};
  endfunction

  // scoreboard: pop on every bundle transfer
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_bundle obs=%0h exp=none",
               {opcode, iaddr, oaddr, operand1, operand2, alu_mode, imm, ill_obs});
      end
      if (exp_q.size() != 0)
        check("bundle", 64'({opcode, iaddr, oaddr, operand1, operand2, alu_mode, imm, ill_obs}),
              64'(exp_q.pop_front()));
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [7:0] b, input logic [DW-1:0] im);
    exp_q.push_back(model(b, im));
    send_byte(b);
    if (has_imm_m(b)) begin
      send_byte(im[7:0]);
      send_byte(im[15:8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rb;
    int wait_n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fields", 64'({opcode, iaddr, oaddr, operand1, operand2, alu_mode, imm, ill_obs}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));

    // MOV 0x0B, one-cycle latency
    send_instr(8'h0B, '0);
    check("mov_latency", 64'(out_valid), 64'd1);
    check("mov_fields", 64'({opcode, iaddr, oaddr}), 64'({OP_MOV, 3'd1, 3'd3}));
    idle(2);

    // back-to-back single-byte instructions
    send_instr(8'h12, '0);
    send_instr(8'h53, '0);
    send_instr(8'h5C, '0);
    send_instr(8'h87, '0);
    send_instr(8'hC2, '0);
    idle(2);

    // LDI 0x45 0x34 0x12 -> imm 0x1234 after last byte
    exp_q.push_back(model(8'h45, 16'h1234));
    send_byte(8'h45);
    check("ldi_no_partial0", 64'(out_valid), 64'd0);
    send_byte(8'h34);
    check("ldi_no_partial1", 64'(out_valid), 64'd0);
    send_byte(8'h12);
    check("ldi_latency", 64'(out_valid), 64'd1);
    check("ldi_imm", 64'(imm), 64'h1234);
    check("ldi_iaddr", 64'(iaddr), 64'd5);
    idle(2);

    send_instr(8'h6D, 16'hBEEF);
    send_instr(8'hC1, 16'hABCD);
    idle(2);

    // stall: ALU held while CMP waits
    out_ready = 1'b0;
    send_instr(8'h81, '0);
    exp_q.push_back(model(8'hC3, '0));
    in_valid = 1'b1; in_byte = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_bundle", 64'({opcode, alu_mode}), 64'({OP_ALU, 4'd1}));
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("cmp_alu_mode", 64'({opcode, alu_mode}), 64'({OP_CMP, AW'(ALU_SUB)}));
    idle(2);

    // flush before LDI immediate; byte offered during flush must be ignored
    send_byte(8'h40);
    flush = 1'b1; in_valid = 1'b1; in_byte = 8'h0B;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_state", 64'(dbg_state), 64'(S_IDLE));
    send_instr(8'hC0, '0);
    check("nop_opcode", 64'(opcode), 64'(OP_NOP));
    idle(2);

    // undefined encoding
    send_instr(8'h70, '0);
    check("undef_illegal", 64'(ill_obs), 64'(TRAP));
    idle(2);

    // reset in the middle of an immediate
    send_byte(8'h45);
    send_byte(8'h11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    check("rst_mid_discard", 64'(out_valid), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));

    // randomized stream with random back-pressure
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk); #2;
          if (tog_en) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      rb = 8'($urandom_range(0, 254));
      send_instr(rb, 16'($urandom_range(0, 65535)));
    end
    tog_en = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // HLT: halted for 10 cycles, byte offered must not be taken
    send_instr(8'hFF, '0);
    in_valid = 1'b1; in_byte = 8'h0B;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_in_ready", 64'(in_ready), 64'd0);
      check("halt_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_halted", 64'(halted), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("halt_rst_in_ready", 64'(in_ready), 64'd1);
    check("halt_rst_state", 64'(dbg_state), 64'(S_IDLE));
    send_instr(8'h3F, '0);

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      wait_n++;
      @(posedge clk);
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, immediate width in bits; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter ALU_MODE_W, default 4, alu_mode width; minimum 3.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all in-flight state.
REQ-006 SHALL have ports in_valid  input  1, in_byte  input  8, in_ready  output  1: the instruction byte stream from fetch.
REQ-007 SHALL have ports out_valid  output  1 and out_ready  input  1: the decoded-bundle handshake.
REQ-008 SHALL have port opcode  output  8  decoded OP_* code.
REQ-009 SHALL have ports iaddr  output  3, oaddr  output  3, operand1  output  3, operand2  output  3: the register fields.
REQ-010 SHALL have ports alu_mode  output  ALU_MODE_W, imm  output  DATA_W, halted  output  1.

Function
REQ-011 A byte SHALL transfer when in_valid and in_ready are both high on a clk edge; a bundle SHALL transfer when out_valid and out_ready are both high on a clk edge.
REQ-012 Encodings: 00dddsss MOV; 01000ddd LDI*; 01001ddd LDX; 01010sss STX; 01011sss PUSH; 01100ddd POP; 01101ccc JMP*; 10000mmm ALU; 11000000 NOP; 11000001 CALL*; 11000010 RET; 11000011 CMP; 11111111 HLT. Here * marks instructions that take an immediate.
REQ-013 Any other encoding SHALL be undefined.
REQ-014 operand1 SHALL be byte[5:3] and operand2 SHALL be byte[2:0].
REQ-015 iaddr SHALL be: MOV operand1; LDI, LDX and POP operand2; ALU REG_A; CALL REG_H; otherwise 0.
REQ-016 oaddr SHALL be: MOV, STX and PUSH operand2; CALL REG_H; otherwise 0.
REQ-017 alu_mode SHALL be: ALU operand2 zero-extended; CMP ALU_SUB; otherwise 0.
REQ-018 imm SHALL be 0 for instructions without an immediate.
REQ-019 The state machine SHALL have states IDLE, IMM, OUT and HALT.
REQ-020 IDLE: in_ready=1. Accepting a starred opcode SHALL go to IMM with byte counter=0; accepting any other opcode SHALL go to OUT.
REQ-021 IMM: in_ready=1. It SHALL collect DATA_W/8 bytes little-endian (first byte into imm[7:0]), then go to OUT.
REQ-022 OUT: out_valid=1, and the bundle SHALL stay stable until transfer.
REQ-023 In OUT, in_ready SHALL equal out_ready; transfer plus a same-cycle byte SHALL decode that byte as in IDLE, giving back-to-back throughput of one single-byte instruction per cycle.
REQ-024 Latency: an opcode byte accepted at edge N SHALL give out_valid at N+1; an immediate instruction SHALL give out_valid one cycle after its last immediate byte.
REQ-025 On transfer of an HLT bundle the block SHALL enter HALT: in_ready=0, out_valid=0, halted=1; only rst or flush SHALL leave HALT.
REQ-026 flush SHALL take priority over every handshake: next state IDLE, counter and imm cleared, out_valid=0.
REQ-027 in_ready SHALL be 0 during the flush cycle, and no byte SHALL be accepted in that cycle.
REQ-028 The immediate byte counter SHALL wrap to 0 on leaving IMM; no partial immediate SHALL ever be presented.
REQ-029 All outputs SHALL be registered except in_ready, which SHALL be combinational from state and out_ready.

Reset
REQ-030 rst high SHALL asynchronously force state IDLE and counter 0.
REQ-031 rst high SHALL force out_valid, halted, opcode, iaddr, oaddr, operand1, operand2, alu_mode and imm to 0; in_ready SHALL read 1 after release.
REQ-032 rst asserted mid-immediate or in OUT SHALL discard the instruction, and no bundle for it SHALL appear after release.

Configuration
REQ-033 Macro DECODE_ILLEGAL_TRAP_EN SHALL select how undefined encodings are handled.
REQ-034 With DECODE_ILLEGAL_TRAP_EN defined, port illegal  output  1 SHALL exist; an undefined encoding SHALL produce a bundle with opcode OP_NOP, illegal=1 and all other fields 0.
REQ-035 With DECODE_ILLEGAL_TRAP_EN defined, illegal SHALL reset to 0.
REQ-036 With DECODE_ILLEGAL_TRAP_EN undefined, the illegal port SHALL be absent and an undefined encoding SHALL decode as OP_NOP.

Structure
REQ-037 OP_*, ALU_*, REG_* and the encoding patterns SHALL live in the shared symbols package, together with the state enum.
REQ-038 The combinational byte-to-fields decode SHALL be a sub-module named instr_field_decode, instantiated once.

Verification
REQ-039 Reset release, then 0x0B (MOV) with out_ready=1 -> out_valid next cycle, opcode OP_MOV, iaddr=1, oaddr=3.
REQ-040 DATA_W=16: bytes 0x45, 0x34, 0x12 -> one bundle OP_LDI, iaddr=5, imm=0x1234, arriving one cycle after 0x12.
REQ-041 Stream 0x81, 0xC3 with out_ready held 0 for 3 cycles -> ALU bundle stable with alu_mode=1 and in_ready=0 while stalled; CMP bundle follows with alu_mode=ALU_SUB; no byte lost or duplicated.
REQ-042 0x40 accepted, then flush before its immediate -> no bundle produced; next 0xC0 decodes as OP_NOP.
REQ-043 0xFF consumed -> halted=1 and in_ready=0 for 10 cycles; rst then releases to IDLE.
REQ-044 With DECODE_ILLEGAL_TRAP_EN defined, 0x70 -> OP_NOP bundle with illegal=1; without the macro -> OP_NOP bundle and no illegal port.
